// File: rtl/primitive_assembly.sv
// Assembles transformed vertices into triangles and queues them for the rasterizer.
// Define TRI_STRIP_EN to assemble triangle strips instead of disjoint triangle lists.
module primitive_assembly #(
  parameter int unsigned VREG_WIDTH   = 64,
  parameter int unsigned OPCODE_WIDTH = 8,
  parameter int unsigned COORD_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter logic [OPCODE_WIDTH-1:0] OP_SETCOLOR       = OPCODE_WIDTH'(1),
  parameter logic [OPCODE_WIDTH-1:0] OP_SETVERTEX      = OPCODE_WIDTH'(2),
  parameter logic [OPCODE_WIDTH-1:0] OP_BEGINPRIMITIVE = OPCODE_WIDTH'(3),
  parameter logic [OPCODE_WIDTH-1:0] OP_ENDPRIMITIVE   = OPCODE_WIDTH'(4)
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_LOCK,
  input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
  input  logic [VREG_WIDTH-1:0]    I_VIn,
  input  logic [VREG_WIDTH-1:0]    I_ColorIn,
  input  logic                     I_TriReady,
  output logic                     O_FRAMESTALL,
  output logic                     O_TriValid,
  output logic [6*COORD_WIDTH-1:0] O_TriCoords,
  output logic [VREG_WIDTH-1:0]    O_TriColor,
  output logic [CNT_WIDTH-1:0]     O_TriCount,
  output logic                     O_Dropped,
  output logic                     O_LOCK
);

  localparam int unsigned VTX_W  = 2 * COORD_WIDTH;
  localparam int unsigned TRI_W  = 3 * VTX_W;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic {StIdle, StCollect} state_t;

  state_t                state;
  logic [1:0]            vcount;
  logic [VTX_W-1:0]      slot0;
  logic [VTX_W-1:0]      slot1;
  logic [VREG_WIDTH-1:0] color;
  logic [TRI_W-1:0]      fifo_coords [FIFO_DEPTH];
  logic [VREG_WIDTH-1:0] fifo_color [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [FCNT_W-1:0]     fifo_count;
  logic [CNT_WIDTH-1:0]  tri_count;
  logic                  dropped;
`ifdef TRI_STRIP_EN
  logic                  tri_odd;
  logic                  had_tri;
`endif

  logic             accept;
  logic             collecting;
  logic             op_color;
  logic             op_vertex;
  logic             op_begin;
  logic             op_end;
  logic             push;
  logic             pop;
  logic             drop_now;
  logic [VTX_W-1:0] vtx_new;
  logic [TRI_W-1:0] tri_new;
  logic             unused_vin;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign O_FRAMESTALL = (fifo_count == FULL_CNT);
  assign O_TriValid   = (fifo_count != '0);
  assign O_TriCoords  = O_TriValid ? fifo_coords[rd_ptr] : '0;
  assign O_TriColor   = O_TriValid ? fifo_color[rd_ptr] : '0;
  assign O_TriCount   = tri_count;
  assign O_Dropped    = dropped;
  assign O_LOCK       = I_LOCK;

  // Opcodes are only honoured when upstream is locked and we are not stalling it.
  assign accept     = I_LOCK && !O_FRAMESTALL;
  assign collecting = (state == StCollect);
  assign op_color   = accept && (I_Opcode == OP_SETCOLOR);
  assign op_vertex  = accept && (I_Opcode == OP_SETVERTEX);
  assign op_begin   = accept && (I_Opcode == OP_BEGINPRIMITIVE);
  assign op_end     = accept && (I_Opcode == OP_ENDPRIMITIVE);

  assign vtx_new    = {I_VIn[32 +: COORD_WIDTH], I_VIn[16 +: COORD_WIDTH]};
  assign unused_vin = ^{I_VIn[VREG_WIDTH-1:32+COORD_WIDTH], I_VIn[15:0]};

  assign push = collecting && op_vertex && (vcount == 2'd2);
  assign pop  = O_TriValid && I_TriReady;

`ifdef TRI_STRIP_EN
  // Odd strip triangles swap v0/v1 so every triangle keeps the same winding.
  assign tri_new  = tri_odd ? {vtx_new, slot0, slot1} : {vtx_new, slot1, slot0};
  assign drop_now = collecting && (op_begin || op_end) && (vcount != 2'd0) && !had_tri;
`else
  assign tri_new  = {vtx_new, slot1, slot0};
  assign drop_now = collecting && (op_begin || op_end) && (vcount != 2'd0);
`endif

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state      <= StIdle;
      vcount     <= '0;
      slot0      <= '0;
      slot1      <= '0;
      color      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tri_count  <= '0;
      dropped    <= 1'b0;
`ifdef TRI_STRIP_EN
      tri_odd    <= 1'b0;
      had_tri    <= 1'b0;
`endif
    end else begin
      dropped <= drop_now;
      if (op_color) begin
        color <= I_ColorIn;
      end

      unique case (state)
        StIdle: begin
          if (op_begin) begin
            state  <= StCollect;
            vcount <= '0;
`ifdef TRI_STRIP_EN
            tri_odd <= 1'b0;
            had_tri <= 1'b0;
`endif
          end
        end
        StCollect: begin
          if (op_vertex) begin
            if (vcount == 2'd2) begin
`ifdef TRI_STRIP_EN
              // Keep the last two vertices; the next vertex closes another triangle.
              slot0   <= slot1;
              slot1   <= vtx_new;
              tri_odd <= ~tri_odd;
              had_tri <= 1'b1;
`else
              vcount <= '0;
`endif
            end else begin
              if (vcount == 2'd0) begin
                slot0 <= vtx_new;
              end else begin
                slot1 <= vtx_new;
              end
              vcount <= vcount + 2'd1;
            end
          end else if (op_begin || op_end) begin
            vcount <= '0;
`ifdef TRI_STRIP_EN
            tri_odd <= 1'b0;
            had_tri <= 1'b0;
`endif
            if (op_end) begin
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase

      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (push && (tri_count != '1)) begin
        tri_count <= tri_count + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while fifo_count says they are valid.
  always_ff @(negedge I_CLOCK) begin
    if (!I_RESET && push) begin
      fifo_coords[wr_ptr] <= tri_new;
      fifo_color[wr_ptr]  <= color;
    end
  end

endmodule

// File: tb/tb_primitive_assembly.sv
// Self-checking bench for primitive_assembly: directed plan steps plus random opcode traffic,
// checked against a queue-based triangle model.
module tb_primitive_assembly;

  localparam int DEPTH = 2;
  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_SETCOLOR = 8'h01;
  localparam logic [7:0] OP_SETVERT  = 8'h02;
  localparam logic [7:0] OP_BEGIN    = 8'h03;
  localparam logic [7:0] OP_END      = 8'h04;

  logic        clk;
  logic        rst;
  logic        lock;
  logic [7:0]  opcode;
  logic [63:0] vin;
  logic [63:0] color_in;
  logic        ready;
  logic        framestall;
  logic        tri_valid;
  logic [95:0] tri_coords;
  logic [63:0] tri_color;
  logic [15:0] tri_count;
  logic        dropped;
  logic        lock_out;

  primitive_assembly #(
    .VREG_WIDTH       (64),
    .OPCODE_WIDTH     (8),
    .COORD_WIDTH      (16),
    .FIFO_DEPTH       (DEPTH),
    .CNT_WIDTH        (16),
    .OP_SETCOLOR      (OP_SETCOLOR),
    .OP_SETVERTEX     (OP_SETVERT),
    .OP_BEGINPRIMITIVE(OP_BEGIN),
    .OP_ENDPRIMITIVE  (OP_END)
  ) dut (
    .I_CLOCK     (clk),
    .I_RESET     (rst),
    .I_LOCK      (lock),
    .I_Opcode    (opcode),
    .I_VIn       (vin),
    .I_ColorIn   (color_in),
    .I_TriReady  (ready),
    .O_FRAMESTALL(framestall),
    .O_TriValid  (tri_valid),
    .O_TriCoords (tri_coords),
    .O_TriColor  (tri_color),
    .O_TriCount  (tri_count),
    .O_Dropped   (dropped),
    .O_LOCK      (lock_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] coords;
    logic [63:0] color;
  } tri_t;

  // Reference model: triangles in flight plus the vertices of the open primitive.
  tri_t        mq[$];
  logic [31:0] pv[$];
  bit          in_prim;
  int          ntri;
  logic [63:0] m_color;
  logic [15:0] m_count;
  bit          m_dropped;
  bit          m_acc;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkv(input logic [15:0] x, input logic [15:0] y);
    return {16'hA5A5, y, x, 16'h5A5A};
  endfunction

  function automatic bit drop_cond();
`ifdef TRI_STRIP_EN
    return (pv.size() != 0) && (ntri == 0);
`else
    return pv.size() != 0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    pv.delete();
    in_prim   = 0;
    ntri      = 0;
    m_color   = '0;
    m_count   = '0;
    m_dropped = 0;
    m_acc     = 0;
  endtask

  task automatic model_push(input logic [95:0] coords);
    tri_t t;
    t.coords = coords;
    t.color  = m_color;
    mq.push_back(t);
    if (m_count != 16'hFFFF) m_count++;
    ntri++;
  endtask

  task automatic model_step();
    bit          do_pop;
    tri_t        t;
    logic [31:0] a, b, c;
    m_acc     = lock && (mq.size() != DEPTH);
    do_pop    = (mq.size() != 0) && ready;
    m_dropped = 0;
    if (do_pop) t = mq.pop_front();
    if (m_acc) begin
      if (opcode == OP_SETCOLOR) begin
        m_color = color_in;
      end else if (opcode == OP_BEGIN) begin
        if (in_prim && drop_cond()) m_dropped = 1;
        in_prim = 1;
        pv.delete();
        ntri = 0;
      end else if (opcode == OP_END && in_prim) begin
        if (drop_cond()) m_dropped = 1;
        in_prim = 0;
        pv.delete();
        ntri = 0;
      end else if (opcode == OP_SETVERT && in_prim) begin
        pv.push_back({vin[47:32], vin[31:16]});
`ifdef TRI_STRIP_EN
        if (pv.size() >= 3) begin
          a = pv[pv.size()-3];
          b = pv[pv.size()-2];
          c = pv[pv.size()-1];
          if (ntri % 2 == 1) model_push({c, a, b});
          else model_push({c, b, a});
        end
`else
        if (pv.size() == 3) begin
          a = pv[0];
          b = pv[1];
          c = pv[2];
          model_push({c, b, a});
          pv.delete();
        end
`endif
      end
    end
  endtask

  task automatic compare_all();
    tri_t head;
    head = '0;
    if (mq.size() != 0) head = mq[0];
    chk("valid", tri_valid, mq.size() != 0);
    chk("coords", tri_coords, head.coords);
    chk("color", tri_color, head.color);
    chk("stall", framestall, mq.size() == DEPTH);
    chk("count", tri_count, m_count);
    chk("dropped", dropped, m_dropped);
    chk("lock", lock_out, lock);
  endtask

  // One falling edge with the given opcode; outputs are compared on the rising edge before it.
  task automatic cycle(input logic [7:0] op, input logic [63:0] v, input logic [63:0] c);
    @(posedge clk);
    compare_all();
    opcode   = op;
    vin      = v;
    color_in = c;
    @(negedge clk);
    #1;
    model_step();
  endtask

  task automatic send(input logic [7:0] op, input logic [63:0] v, input logic [63:0] c);
    int tries;
    tries = 0;
    m_acc = 0;
    while (!m_acc && tries < 20) begin
      cycle(op, v, c);
      tries++;
    end
    if (!m_acc) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout observed=%0d expected=accepted op=%0h", tries, op);
    end
  endtask

  task automatic reset_checks();
    chk("rst_valid", tri_valid, 1'b0);
    chk("rst_count", tri_count, 16'd0);
    chk("rst_stall", framestall, 1'b0);
    chk("rst_dropped", dropped, 1'b0);
    chk("rst_coords", tri_coords, 96'd0);
    chk("rst_color", tri_color, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    reset_checks();
    @(posedge clk);
    rst    = 0;
    opcode = OP_NOP;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] op;
    clk = 0; rst = 1; lock = 0; ready = 0;
    opcode = OP_NOP; vin = '0; color_in = '0;
    model_reset();
    #2;
    reset_checks();
    @(posedge clk);
    rst = 0;

    // Single triangle with colour, drained immediately.
    lock = 1; ready = 1;
    send(OP_BEGIN, '0, '0);
    send(OP_SETCOLOR, '0, 64'h00FF00FF00FF00FF);
    send(OP_SETVERT, mkv(1, 2), '0);
    send(OP_SETVERT, mkv(3, 4), '0);
    send(OP_SETVERT, mkv(5, 6), '0);
    chk("t1_valid", tri_valid, 1'b1);
    chk("t1_coords", tri_coords, 96'h0006_0005_0004_0003_0002_0001);
    chk("t1_color", tri_color, 64'h00FF00FF00FF00FF);
    chk("t1_count", tri_count, 16'd1);
    cycle(OP_NOP, '0, '0);
    chk("t1_popped", tri_valid, 1'b0);

    // Back-pressure: FIFO fills, stall holds the next vertex, then drains in order.
    do_reset();
    ready = 0;
    send(OP_BEGIN, '0, '0);
    for (int i = 0; i < 6; i++) send(OP_SETVERT, mkv(16'(10 + i), 16'(20 + i)), '0);
    repeat (3) cycle(OP_SETVERT, mkv(16, 26), '0);
    chk("t2_stall", framestall, 1'b1);
    chk("t2_count2", tri_count, 16'd2);
    ready = 1;
    for (int i = 6; i < 9; i++) send(OP_SETVERT, mkv(16'(10 + i), 16'(20 + i)), '0);
    repeat (4) cycle(OP_NOP, '0, '0);
    chk("t2_count", tri_count, 16'd3);
    chk("t2_empty", tri_valid, 1'b0);

    // Partial primitive is dropped; vertices outside a primitive are ignored.
    do_reset();
    send(OP_BEGIN, '0, '0);
    send(OP_SETVERT, mkv(7, 8), '0);
    send(OP_SETVERT, mkv(9, 10), '0);
    send(OP_END, '0, '0);
    chk("t3_dropped", dropped, 1'b1);
    cycle(OP_NOP, '0, '0);
    chk("t3_pulse_end", dropped, 1'b0);
    for (int i = 0; i < 3; i++) send(OP_SETVERT, mkv(16'(30 + i), 16'(31 + i)), '0);
    repeat (2) cycle(OP_NOP, '0, '0);
    chk("t3_no_push", tri_count, 16'd0);

    // Lock low: vertex ignored but the pending pop still happens.
    do_reset();
    ready = 0;
    send(OP_BEGIN, '0, '0);
    for (int i = 0; i < 3; i++) send(OP_SETVERT, mkv(16'(1 + i), 16'(2 + i)), '0);
    send(OP_SETVERT, mkv(40, 41), '0);
    lock = 0; ready = 1;
    cycle(OP_SETVERT, mkv(50, 51), '0);
    cycle(OP_NOP, '0, '0);
    chk("t4_pop", tri_valid, 1'b0);
    lock = 1; ready = 0;
    send(OP_SETVERT, mkv(42, 43), '0);
    send(OP_SETVERT, mkv(44, 45), '0);
`ifndef TRI_STRIP_EN
    chk("t4_coords", tri_coords, 96'h002D_002C_002B_002A_0029_0028);
`endif
    ready = 1;
    repeat (3) cycle(OP_NOP, '0, '0);

    // Asynchronous reset mid-primitive with a triangle queued.
    do_reset();
    ready = 0;
    send(OP_BEGIN, '0, '0);
    for (int i = 0; i < 4; i++) send(OP_SETVERT, mkv(16'(60 + i), 16'(70 + i)), '0);
    chk("t5_queued", tri_valid, 1'b1);
    do_reset();

`ifdef TRI_STRIP_EN
    // Strip A..E yields (A,B,C), (C,B,D), (C,D,E).
    ready = 0;
    send(OP_BEGIN, '0, '0);
    for (int i = 0; i < 4; i++) send(OP_SETVERT, mkv(16'(1 + i), 16'(11 + i)), '0);
    chk("ts_head", tri_coords, 96'h000D_0003_000C_0002_000B_0001);
    ready = 1;
    send(OP_SETVERT, mkv(5, 15), '0);
    send(OP_END, '0, '0);
    chk("ts_no_drop", dropped, 1'b0);
    repeat (4) cycle(OP_NOP, '0, '0);
    chk("ts_count", tri_count, 16'd3);
    do_reset();
`endif

    // Random traffic against the model, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      lock  = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 99);
      if (r < 50) op = OP_SETVERT;
      else if (r < 62) op = OP_BEGIN;
      else if (r < 72) op = OP_END;
      else if (r < 82) op = OP_SETCOLOR;
      else op = 8'($urandom_range(0, 255));
      cycle(op, {$urandom, $urandom}, {$urandom, $urandom});
      if (i == 200) do_reset();
    end
    lock = 1; ready = 1;
    repeat (4) cycle(OP_NOP, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
